// File: rtl/wb_master_port.sv
// wb_master_port: single-outstanding pipelined Wishbone initiator.
// A command is taken on a valid/ready interface and driven as one bus transaction.
// The result comes back as read data or an error on a valid/ready response interface.
// Optional feature macro: WBM_TIMEOUT_EN aborts a transaction that sees no ack/err
// within TO_CYC cycles of REQ+WAIT and reports it as an error.
module wb_master_port #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 3,
  parameter int unsigned TO_CYC = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_we,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_data,
  input  logic [DW/8-1:0] i_cmd_sel,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_data,
  output logic            o_rsp_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_d;
  logic            cyc_d, stb_d, we_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   wdata_d;
  logic [SW-1:0]   sel_d;
  logic            rsp_valid_d, rsp_err_d;
  logic [DW-1:0]   rsp_data_d;
  logic            done_c;

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYC) + 1;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d     = state_q;
    cyc_d       = o_wb_cyc;
    stb_d       = o_wb_stb;
    we_d        = o_wb_we;
    addr_d      = o_wb_addr;
    wdata_d     = o_wb_data;
    sel_d       = o_wb_sel;
    rsp_valid_d = o_rsp_valid;
    rsp_data_d  = o_rsp_data;
    rsp_err_d   = o_rsp_err;
    done_c      = 1'b0;
`ifdef WBM_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          state_d = REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_data;
          sel_d   = i_cmd_sel;
`ifdef WBM_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      REQ: begin
        // Strobe is accepted only on a non-stalled edge; ack/err counts only then.
        if (!i_wb_stall) begin
          stb_d = 1'b0;
          if (i_wb_ack || i_wb_err) done_c = 1'b1;
          else                      state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_wb_ack || i_wb_err) done_c = 1'b1;
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus completion: error wins over ack, writes and errors return zero data.
    if (done_c) begin
      state_d     = RESP;
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = i_wb_err;
      rsp_data_d  = (!o_wb_we && i_wb_ack && !i_wb_err) ? i_wb_data : '0;
    end

`ifdef WBM_TIMEOUT_EN
    // Abort a transaction whose responder never answers.
    if (state_q == REQ || state_q == WAIT) begin
      to_cnt_d = to_cnt_q + CW'(1);
      if (!done_c && to_cnt_q == CW'(TO_CYC - 1)) begin
        state_d     = RESP;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_data_d  = '0;
      end
    end
`endif

    cmd_ready_d = (state_d == IDLE);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Output registers; reset drops the bus cycle and any pending response at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_cmd_ready <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      o_wb_sel    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      o_cmd_ready <= cmd_ready_d;
      o_wb_cyc    <= cyc_d;
      o_wb_stb    <= stb_d;
      o_wb_we     <= we_d;
      o_wb_addr   <= addr_d;
      o_wb_data   <= wdata_d;
      o_wb_sel    <= sel_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_data  <= rsp_data_d;
      o_rsp_err   <= rsp_err_d;
    end
  end

`ifdef WBM_TIMEOUT_EN
  // Timeout counter register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end
`endif

endmodule

// File: tb/tb_wb_master_port.sv
// Testbench for wb_master_port against a 2-cycle registered-ack memory responder.
module tb_wb_master_port;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_we;
  logic [2:0]  i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic [3:0]  i_cmd_sel;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_err;
  logic [31:0] o_rsp_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;

  int vectors = 0;
  int miscompares = 0;

  // Responder controls (written by stimulus only).
  int   stall_req = 0;
  logic rsp_err_mode = 1'b0;
  logic rsp_none = 1'b0;

  // Responder state (written by responder only).
  int          stall_done;
  logic        pend;
  logic [31:0] pend_rd;
  logic [31:0] resp_mem [8] = '{default: 32'hFFFF_FFFF};

  // Reference model state.
  logic [31:0] model_mem [8] = '{default: 32'hFFFF_FFFF};
  logic [32:0] expq [$];
  logic        cur_we;
  logic [2:0]  cur_addr;
  logic [31:0] cur_data;
  logic [3:0]  cur_sel;
  int          stb_cycles, ack_cycles;

  always #5 i_clk = ~i_clk;

  wb_master_port #(.DW(32), .AW(3), .TO_CYC(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_sel(i_cmd_sel),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  assign i_wb_stall = (stall_done < stall_req);

  // Memory responder: accept on stb&!stall, ack (or err) registered two edges later.
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pend <= 1'b0; i_wb_ack <= 1'b0; i_wb_err <= 1'b0;
      i_wb_data <= '0; stall_done <= 0; pend_rd <= '0;
    end else begin
      i_wb_ack <= 1'b0;
      i_wb_err <= 1'b0;
      if (pend) begin
        pend <= 1'b0;
        if (!rsp_none) begin
          if (rsp_err_mode) i_wb_err <= 1'b1;
          else begin i_wb_ack <= 1'b1; i_wb_data <= pend_rd; end
        end
      end
      if (o_wb_cyc && o_wb_stb) begin
        if (i_wb_stall) stall_done <= stall_done + 1;
        else begin
          pend <= 1'b1;
          stall_done <= 0;
          pend_rd <= resp_mem[o_wb_addr];
          if (o_wb_we && !rsp_err_mode && !rsp_none)
            for (int b = 0; b < 4; b++)
              if (o_wb_sel[b]) resp_mem[o_wb_addr][8*b +: 8] <= o_wb_data[8*b +: 8];
        end
      end
    end
  end

  // Per-cycle compare against the model on the falling edge.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      check("stb_implies_cyc", 32'(o_wb_stb & ~o_wb_cyc), 32'd0);
      if (o_wb_cyc) begin
        check("wb_we", 32'(o_wb_we), 32'(cur_we));
        check("wb_addr", 32'(o_wb_addr), 32'(cur_addr));
        check("wb_data", o_wb_data, cur_data);
        check("wb_sel", 32'(o_wb_sel), 32'(cur_sel));
      end
      if (o_wb_stb) stb_cycles++;
      if (i_wb_ack && o_wb_cyc) ack_cycles++;
      if (o_rsp_valid) begin
        check("ready_during_rsp", 32'(o_cmd_ready), 32'd0);
        check("cyc_during_rsp", 32'(o_wb_cyc), 32'd0);
        if (expq.size() == 0) check("unexpected_rsp", 32'(o_rsp_valid), 32'd0);
        else begin
          check("rsp_data", o_rsp_data, expq[0][31:0]);
          check("rsp_err", 32'(o_rsp_err), 32'(expq[0][32]));
          if (i_rsp_ready) void'(expq.pop_front());
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!o_cmd_ready && n < 50) begin @(posedge i_clk); #1; n++; end
    check("cmd_ready", 32'(o_cmd_ready), 32'd1);
  endtask

  // mode: 0 ack, 1 err, 2 no answer
  task automatic do_cmd(input logic we, input logic [2:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, input int stalls, input int mode, input int hold,
                        output logic [31:0] rdata, output logic rerr, output int cyc_edges);
    logic [32:0] e;
    wait_ready();
    stall_req = stalls;
    rsp_err_mode = (mode == 1);
    rsp_none = (mode == 2);
    cur_we = we; cur_addr = addr; cur_data = data; cur_sel = sel;
    if (mode != 0) e = {1'b1, 32'd0};
    else if (we) begin model_mem[addr] = merge(model_mem[addr], data, sel); e = {1'b0, 32'd0}; end
    else e = {1'b0, model_mem[addr]};
    expq.push_back(e);
    i_cmd_we = we; i_cmd_addr = addr; i_cmd_data = data; i_cmd_sel = sel;
    i_cmd_valid = 1'b1;
    stb_cycles = 0; ack_cycles = 0;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    cyc_edges = 0;
    while (o_wb_cyc && cyc_edges < 100) begin @(posedge i_clk); #1; cyc_edges++; end
    check("rsp_valid_at_cyc_drop", 32'(o_rsp_valid), 32'd1);
    repeat (hold) begin @(posedge i_clk); #1; end
    rdata = o_rsp_data;
    rerr = o_rsp_err;
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 32'(o_rsp_valid), 32'd0);
    check("ready_after_hs", 32'(o_cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        re;
    int          ce;
    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = '0;
    i_cmd_data = '0; i_cmd_sel = '0; i_rsp_ready = 1'b0;
    cur_we = 1'b0; cur_addr = '0; cur_data = '0; cur_sel = '0;
    stb_cycles = 0; ack_cycles = 0;
    #2;
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    check("rst_cyc", 32'(o_wb_cyc), 32'd0);
    check("rst_stb", 32'(o_wb_stb), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    check("rst_wb_addr_data", 32'(o_wb_addr) | o_wb_data, 32'd0);
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(posedge i_clk); #1;
    check("ready_after_reset", 32'(o_cmd_ready), 32'd1);

    // 1: full write then read back
    do_cmd(1'b1, 3'd5, 32'hDEADBEEF, 4'hF, 0, 0, 0, rd, re, ce);
    check("t1_wr_data", rd, 32'd0);
    check("t1_wr_err", 32'(re), 32'd0);
    check("t1_cyc_edges", 32'(ce), 32'd3);
    check("t1_stb_cycles", 32'(stb_cycles), 32'd1);
    check("t1_acks", 32'(ack_cycles), 32'd1);
    do_cmd(1'b0, 3'd5, 32'h0, 4'hF, 0, 0, 0, rd, re, ce);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_err", 32'(re), 32'd0);

    // 2: partial byte-select write over reset contents
    do_cmd(1'b1, 3'd2, 32'h11223344, 4'h5, 0, 0, 0, rd, re, ce);
    do_cmd(1'b0, 3'd2, 32'h0, 4'h0, 0, 0, 0, rd, re, ce);
    check("t2_rd_data", rd, 32'hFF22FF44);

    // 3: three stall cycles
    do_cmd(1'b0, 3'd5, 32'hA5A5A5A5, 4'hC, 3, 0, 0, rd, re, ce);
    check("t3_stb_cycles", 32'(stb_cycles), 32'd4);
    check("t3_acks", 32'(ack_cycles), 32'd1);
    check("t3_cyc_edges", 32'(ce), 32'd6);
    check("t3_rd_data", rd, 32'hDEADBEEF);

    // 4: response back-pressure
    do_cmd(1'b0, 3'd2, 32'h0, 4'hF, 0, 0, 5, rd, re, ce);
    check("t4_rd_data", rd, 32'hFF22FF44);

    // 5: bus error on a write and a read; zero-select write
    do_cmd(1'b1, 3'd3, 32'h01020304, 4'hF, 0, 1, 0, rd, re, ce);
    check("t5_wr_err", 32'(re), 32'd1);
    check("t5_wr_data", rd, 32'd0);
    check("t5_acks", 32'(ack_cycles), 32'd0);
    do_cmd(1'b0, 3'd5, 32'h0, 4'hF, 0, 1, 0, rd, re, ce);
    check("t5_rd_err", 32'(re), 32'd1);
    check("t5_rd_data", rd, 32'd0);
    do_cmd(1'b1, 3'd4, 32'h12345678, 4'h0, 0, 0, 0, rd, re, ce);
    check("t5_sel0_edges", 32'(ce), 32'd3);
    do_cmd(1'b0, 3'd4, 32'h0, 4'hF, 0, 0, 0, rd, re, ce);
    check("t5_sel0_rd", rd, 32'hFFFFFFFF);
`ifdef WBM_TIMEOUT_EN
    do_cmd(1'b0, 3'd1, 32'h0, 4'hF, 0, 2, 0, rd, re, ce);
    check("t5_to_edges", 32'(ce), 32'd16);
    check("t5_to_err", 32'(re), 32'd1);
    check("t5_to_data", rd, 32'd0);
`endif

    // 6: reset while waiting for ack
    wait_ready();
    stall_req = 0; rsp_err_mode = 1'b0; rsp_none = 1'b0;
    cur_we = 1'b0; cur_addr = 3'd5; cur_data = 32'h0; cur_sel = 4'hF;
    i_cmd_we = 1'b0; i_cmd_addr = 3'd5; i_cmd_data = 32'h0; i_cmd_sel = 4'hF;
    i_cmd_valid = 1'b1;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    @(posedge i_clk); #1;
    check("t6_wait_cyc", 32'(o_wb_cyc), 32'd1);
    check("t6_wait_stb", 32'(o_wb_stb), 32'd0);
    i_reset = 1'b1;
    #1;
    check("t6_rst_cyc", 32'(o_wb_cyc), 32'd0);
    check("t6_rst_stb", 32'(o_wb_stb), 32'd0);
    check("t6_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    repeat (4) begin @(posedge i_clk); #1; end
    check("t6_no_rsp", 32'(o_rsp_valid), 32'd0);
    do_cmd(1'b0, 3'd5, 32'h0, 4'hF, 0, 0, 0, rd, re, ce);
    check("t6_rd_data", rd, 32'hDEADBEEF);
    check("t6_rd_err", 32'(re), 32'd0);
    check("t6_queue_empty", 32'(expq.size()), 32'd0);

    repeat (2) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
